mio_bus_arbiter: RTL and testbench

//  Shares one synchronous memory port between the multi-cycle CPU (master 0) and a DMA/peripheral master (master 1).

---
 rtl/mio_bus_pkg.sv | 18 +
 rtl/rr_arb2.sv | 34 +++
 rtl/mio_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_mio_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_pkg.sv
// Shared definitions for the CPU/DMA memory port arbiter.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DMA  = 2'b10;

  // Largest supported memory latency; sizes the WAIT counter.
  localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a registered last-grant pointer.
module rr_arb2
  import mio_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 = DMA was served last, so the CPU wins the next tie.
  logic last_dma;

  // Single requester always wins; on a tie the master not served last wins.
  always_comb begin
    gnt = GRANT_NONE;
    if (req == 2'b11) begin
      gnt = last_dma ? GRANT_CPU : GRANT_DMA;
    end else begin
      gnt = req;
    end
  end

  // Remember who was granted, only when a grant is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dma <= 1'b1;
    end else if (update && (gnt != GRANT_NONE)) begin
      last_dma <= gnt[1];
    end
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one synchronous memory port between the CPU (master 0) and a DMA
// master (master 1). Each transfer is latched in IDLE, issued once in ACCESS,
// waits MEM_LAT cycles for read data and completes with a one-cycle ready.
module mio_bus_arbiter
  import mio_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam int            CNT_W    = $clog2(MEM_LAT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic             we_q;
  logic [1:0]       arb_gnt;
  logic             take_grant;
  logic             last_wait;

  assign take_grant = (state == S_IDLE) && (arb_gnt != GRANT_NONE);
  assign last_wait  = (state == S_WAIT) && (lat_cnt == LAT_LAST);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({dma_req, cpu_req}),
    .update (state == S_IDLE),
    .gnt    (arb_gnt)
  );

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe decode: mem_en only in ACCESS, ready only in DONE.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    dma_ready = 1'b0;
    unique case (state)
      S_IDLE:   if (arb_gnt != GRANT_NONE) state_nxt = S_ACCESS;
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        state_nxt = S_WAIT;
      end
      S_WAIT:   if (lat_cnt == LAT_LAST) state_nxt = S_DONE;
      S_DONE: begin
        cpu_ready = (grant == GRANT_CPU);
        dma_ready = (grant == GRANT_DMA);
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // WAIT counter runs 1..MEM_LAT; loaded with 1 on the way out of ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (state == S_ACCESS) begin
      lat_cnt <= CNT_W'(1);
    end else if (state == S_WAIT) begin
      lat_cnt <= lat_cnt + CNT_W'(1);
    end
  end

  // Latch the winner's request at grant time; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= GRANT_NONE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take_grant) begin
      grant     <= arb_gnt;
      we_q      <= arb_gnt[1] ? dma_we    : cpu_we;
      mem_addr  <= arb_gnt[1] ? dma_addr  : cpu_addr;
      mem_wdata <= arb_gnt[1] ? dma_wdata : cpu_wdata;
    end else if (state == S_DONE) begin
      grant     <= GRANT_NONE;
    end
  end

  // Read data lands in the owner's register in the last WAIT cycle; writes leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (last_wait && !we_q) begin
      if (grant == GRANT_CPU) cpu_rdata <= mem_rdata;
      if (grant == GRANT_DMA) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-schedule model.
module tb_mio_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ready;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    grant;

  mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM contents seen by reads.
  function automatic logic [31:0] ram_read(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // RAM: read data valid exactly MEM_LAT cycles after the mem_en cycle, noise otherwise.
  bit          ram_pend = 0;
  int          ram_cnt = 0;
  logic [31:0] ram_val = '0;
  initial forever begin
    @(posedge clk); #1;
    if (reset) ram_pend = 0;
    if (ram_pend) begin
      ram_cnt--;
      if (ram_cnt == 0) begin
        mem_rdata = ram_val;
        ram_pend  = 0;
      end else mem_rdata = $urandom;
    end else mem_rdata = $urandom;
    if (mem_en && !mem_we && !reset) begin
      ram_pend = 1;
      ram_cnt  = L;
      ram_val  = ram_read(mem_addr);
    end
  end

  // Reference model: a transfer accepted in cycle s owns cycles s+1..s+2+L.
  bit          m_busy = 0;
  int          m_d = 0;
  bit          m_owner = 0;
  bit          m_we = 0;
  bit          m_last_dma = 1;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};

  int          cyc = 0;
  int          en_count = 0, cr_count = 0, dr_count = 0;
  int          en_cyc = -1, cr_cyc = -1, dr_cyc = -1;
  logic [31:0] en_addr = '0, en_wdata = '0;
  logic        en_we = 1'b0;
  logic [1:0]  glog [$];

  task automatic model_sample();
    if (!m_busy && (cpu_req || dma_req)) begin
      if (cpu_req && dma_req) m_owner = m_last_dma ? 1'b0 : 1'b1;
      else                    m_owner = dma_req;
      m_last_dma = m_owner;
      m_busy  = 1;
      m_d     = 0;
      m_we    = m_owner ? dma_we    : cpu_we;
      m_addr  = m_owner ? dma_addr  : cpu_addr;
      m_wdata = m_owner ? dma_wdata : cpu_wdata;
    end
  endtask

  task automatic cycle();
    logic       e_en, e_we, e_cr, e_dr;
    logic [1:0] e_gnt;
    model_sample();
    @(posedge clk); #1;
    cyc++;
    if (m_busy) begin
      m_d++;
      if (m_d == 3 + L) m_busy = 0;
    end
    if (m_busy && m_d == 2 + L && !m_we) m_rdata[m_owner] = ram_read(m_addr);
    e_en  = m_busy && (m_d == 1);
    e_we  = e_en && m_we;
    e_gnt = !m_busy ? 2'b00 : (m_owner ? 2'b10 : 2'b01);
    e_cr  = m_busy && (m_d == 2 + L) && !m_owner;
    e_dr  = m_busy && (m_d == 2 + L) && m_owner;
    if (mem_en) begin
      en_count++; en_cyc = cyc; glog.push_back(grant);
      en_addr = mem_addr; en_wdata = mem_wdata; en_we = mem_we;
    end
    if (cpu_ready) begin cr_count++; cr_cyc = cyc; end
    if (dma_ready) begin dr_count++; dr_cyc = cyc; end
    check_eq("mem_en",    mem_en,    e_en);
    check_eq("mem_we",    mem_we,    e_we);
    check_eq("grant",     grant,     e_gnt);
    check_eq("cpu_ready", cpu_ready, e_cr);
    check_eq("dma_ready", dma_ready, e_dr);
    check_eq("cpu_rdata", cpu_rdata, m_rdata[0]);
    check_eq("dma_rdata", dma_rdata, m_rdata[1]);
    check_eq("mem_addr",  mem_addr,  m_addr);
    check_eq("mem_wdata", mem_wdata, m_wdata);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_mem_en",    mem_en,    1'b0);
    check_eq("rst_mem_we",    mem_we,    1'b0);
    check_eq("rst_grant",     grant,     2'b00);
    check_eq("rst_cpu_ready", cpu_ready, 1'b0);
    check_eq("rst_dma_ready", dma_ready, 1'b0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_eq("rst_dma_rdata", dma_rdata, 32'h0);
    check_eq("rst_mem_addr",  mem_addr,  32'h0);
    m_busy = 0; m_last_dma = 1; m_addr = '0; m_wdata = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, e0, c0, d0;
    // Power-on reset
    #1;
    check_eq("por_mem_en", mem_en, 1'b0);
    check_eq("por_grant",  grant,  2'b00);
    check_eq("por_cpu_rdata", cpu_rdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset during WAIT, then a normal CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    cycle(); cpu_req = 0;
    cycle();
    do_reset();
    cpu_req = 1; cpu_addr = 32'h10;
    cycle(); cpu_req = 0;
    repeat (5) cycle();
    check_eq("t1_rdata", cpu_rdata, 32'hDEADBEEF);

    // CPU read with exact latency
    do_reset();
    t0 = cyc; e0 = en_count; c0 = cr_count;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    cycle(); cpu_req = 0; cpu_addr = 32'h44;
    repeat (5) cycle();
    check_eq("t2_en_cyc",    en_cyc - t0, 1);
    check_eq("t2_ready_cyc", cr_cyc - t0, 4);
    check_eq("t2_en_count",  en_count - e0, 1);
    check_eq("t2_rdy_count", cr_count - c0, 1);
    check_eq("t2_rdata",     cpu_rdata, 32'hDEADBEEF);

    // Simultaneous requests after reset: CPU first, then DMA
    do_reset();
    t0 = cyc;
    cpu_req = 1; cpu_addr = 32'h200; dma_req = 1; dma_we = 0; dma_addr = 32'h300;
    cycle(); cpu_req = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (dma_ready) dma_req = 0;
    end
    check_eq("t3_cpu_ready_cyc", cr_cyc - t0, 4);
    check_eq("t3_dma_ready_cyc", dr_cyc - t0, 9);

    // Both held high for four transfers: strict alternation
    do_reset();
    glog.delete();
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 4 * (3 + L); i++) begin
      cpu_addr = $urandom; dma_addr = $urandom; cpu_we = $urandom_range(0, 1); dma_we = $urandom_range(0, 1);
      cycle();
    end
    cpu_req = 0; dma_req = 0;
    repeat (6) cycle();
    check_eq("t4_count", glog.size(), 4);
    if (glog.size() == 4) begin
      check_eq("t4_g0", glog[0], 2'b01);
      check_eq("t4_g1", glog[1], 2'b10);
      check_eq("t4_g2", glog[2], 2'b01);
      check_eq("t4_g3", glog[3], 2'b10);
    end

    // DMA write
    e0 = en_count; d0 = dr_count;
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'h12345678;
    cycle(); dma_req = 0; dma_we = 0;
    repeat (5) cycle();
    check_eq("t5_en_count", en_count - e0, 1);
    check_eq("t5_we",       en_we, 1'b1);
    check_eq("t5_addr",     en_addr, 32'h100);
    check_eq("t5_wdata",    en_wdata, 32'h12345678);
    check_eq("t5_rdy_count", dr_count - d0, 1);

    // CPU drops request and changes address mid-WAIT
    e0 = en_count; c0 = cr_count;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    cycle(); cycle();
    cpu_req = 0; cpu_addr = 32'h20;
    repeat (6) cycle();
    check_eq("t6_en_count",  en_count - e0, 1);
    check_eq("t6_rdy_count", cr_count - c0, 1);
    check_eq("t6_mem_addr",  mem_addr, 32'h10);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cpu_req   = $urandom_range(0, 1);
      dma_req   = $urandom_range(0, 1);
      cpu_we    = $urandom_range(0, 1);
      dma_we    = $urandom_range(0, 1);
      cpu_addr  = ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom;
      dma_addr  = $urandom;
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
